// File: rtl/gc_sched_pkg.sv
// Shared types for the graphics command scheduler: opcodes, FSM states,
// the queued command record and small opcode helpers.
package gc_sched_pkg;

  typedef enum logic [7:0] {
    OP_NOP      = 8'h00,
    OP_FONT     = 8'h02,
    OP_BG       = 8'h03,
    OP_CLR_SCR  = 8'h04,
    OP_CLR_LINE = 8'h05
  } gc_op_e;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT_VS,
    CLR_START,
    CLR_ACK,
    CLR_DONE
  } sched_state_e;

  // op is kept as a raw byte so illegal opcodes survive the FIFO and can be
  // flagged at decode time.
  typedef struct packed {
    logic [7:0] op;
    logic [7:0] arg;
  } gc_cmd_t;

  // Start-pulse instruction byte for a clear: 0x04 or 0x05 by the op LSB.
  function automatic logic [7:0] clr_instr(input logic op_lsb);
    return {5'b0, 1'b1, 1'b0, op_lsb};
  endfunction

  function automatic logic is_valid_op(input logic [7:0] op);
    return op inside {OP_FONT, OP_BG, OP_CLR_SCR, OP_CLR_LINE};
  endfunction

endpackage

// File: rtl/gc_cmd_scheduler_if.sv
// CPU-side command handshake into the scheduler.
interface gc_cmd_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_op;
  logic [7:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/gc_cmd_fifo.sv
// Command FIFO. Pointers carry one extra wrap bit so full and empty can be
// told apart without a separate occupancy counter.
module gc_cmd_fifo
  import gc_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  gc_cmd_t wr_data,
  input  logic    pop,
  output gc_cmd_t rd_data,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  gc_cmd_t       mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign rd_data = mem[rptr[AW-1:0]];

  // storage write; contents are don't-care until the pointers cover them
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wr_data;
  end

  // pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/gc_cmd_scheduler.sv
// Graphics command scheduler: queues CPU commands and issues them one at a
// time to the graphics card. Colour changes wait for a v_sync falling edge;
// clears pulse the engine start and wait for clear_busy to rise and fall.
// Optional statistics counters (cmd_count, drop_count) exist only when
// GC_SCHED_STATS_EN is defined.
module gc_cmd_scheduler
  import gc_sched_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  gc_cmd_scheduler_if.slave    cmd,
  input  logic                 v_sync,
  input  logic                 clear_busy,
  output logic [7:0]           gc_instruction,
  output logic [7:0]           gc_color,
  output logic [4:0]           gc_row,
  output logic                 busy,
  output logic                 err
`ifdef GC_SCHED_STATS_EN
  ,
  output logic [15:0]          cmd_count,
  output logic [7:0]           drop_count
`endif
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  sched_state_e  state;
  gc_cmd_t       cur;
  gc_cmd_t       head;
  gc_cmd_t       wr_cmd;
  logic [TW-1:0] ack_cnt;
  logic          vs_q;
  logic          vs_fall;
  logic          ack_last;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  assign wr_cmd        = {cmd.cmd_op, cmd.cmd_arg};
  assign cmd.cmd_ready = !fifo_full;
  assign pop           = (state == IDLE) && !fifo_empty;
  assign vs_fall       = vs_q && !v_sync;
  assign ack_last      = (ack_cnt == TW'(ACK_TIMEOUT - 1));
  assign busy          = !fifo_empty || (state != IDLE);

  gc_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd.cmd_valid),
    .wr_data (wr_cmd),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // sequencer FSM with registered card-facing outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cur            <= '0;
      ack_cnt        <= '0;
      vs_q           <= 1'b0;
      gc_instruction <= '0;
      gc_color       <= '0;
      gc_row         <= '0;
      err            <= 1'b0;
    end else begin
      vs_q <= v_sync;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur   <= head;
            state <= DECODE;
          end
        end
        DECODE: begin
          case (cur.op)
            OP_FONT, OP_BG: begin
              gc_instruction <= cur.op;
              gc_color       <= cur.arg;
              state          <= WAIT_VS;
            end
            OP_CLR_SCR, OP_CLR_LINE: begin
              gc_instruction <= clr_instr(cur.op[0]);
              gc_row         <= (cur.op == OP_CLR_LINE) ? cur.arg[4:0] : 5'd0;
              state          <= CLR_START;
            end
            default: begin
              err   <= 1'b1;
              state <= IDLE;
            end
          endcase
        end
        // hold the colour instruction until the frame boundary
        WAIT_VS: begin
          if (vs_fall) begin
            gc_instruction <= '0;
            state          <= IDLE;
          end
        end
        CLR_START: begin
          gc_instruction <= '0;
          ack_cnt        <= '0;
          state          <= CLR_ACK;
        end
        // engine must acknowledge within ACK_TIMEOUT cycles or the clear is abandoned
        CLR_ACK: begin
          if (clear_busy) begin
            state <= CLR_DONE;
          end else if (ack_last) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + TW'(1);
          end
        end
        CLR_DONE: begin
          if (!clear_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GC_SCHED_STATS_EN
  logic ev_drop;
  logic ev_done;

  assign ev_drop = ((state == DECODE) && !is_valid_op(cur.op)) ||
                   ((state == CLR_ACK) && !clear_busy && ack_last);
  assign ev_done = ((state == WAIT_VS) && vs_fall) ||
                   ((state == CLR_DONE) && !clear_busy);

  // command and drop statistics; drop counter saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_count  <= '0;
      drop_count <= '0;
    end else begin
      if (ev_drop || ev_done) cmd_count <= cmd_count + 16'd1;
      if (ev_drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gc_cmd_scheduler.sv
// Self-checking bench for gc_cmd_scheduler: vector table, hand-written
// corner sequences and a randomized run scored against an in-order
// transaction model.
module tb_gc_cmd_scheduler;
  import gc_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gc_cmd_scheduler_if cif();

  logic man_vs = 1'b0, man_busy = 1'b0, gen_vs = 1'b0, eng_busy = 1'b0, auto_en = 1'b0;
  logic v_sync, clear_busy;
  assign v_sync     = auto_en ? gen_vs   : man_vs;
  assign clear_busy = auto_en ? eng_busy : man_busy;

  logic [7:0] gc_instruction, gc_color;
  logic [4:0] gc_row;
  logic       busy, err;
`ifdef GC_SCHED_STATS_EN
  logic [15:0] cmd_count;
  logic [7:0]  drop_count;
`endif

  gc_cmd_scheduler #(.FIFO_DEPTH(4), .ACK_TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cif.slave),
    .v_sync         (v_sync),
    .clear_busy     (clear_busy),
    .gc_instruction (gc_instruction),
    .gc_color       (gc_color),
    .gc_row         (gc_row),
    .busy           (busy),
    .err            (err)
`ifdef GC_SCHED_STATS_EN
    ,
    .cmd_count      (cmd_count),
    .drop_count     (drop_count)
`endif
  );

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] arg);
    int n = 0;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_arg   = arg;
    while (!cif.cmd_ready && n < 300) begin
      tick(1);
      n++;
    end
    chk("push_accept", 32'(cif.cmd_ready), 32'd1);
    tick(1);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_instr();
    int n = 0;
    while (gc_instruction == 8'h00 && n < 200) begin
      tick(1);
      n++;
    end
    chk("instr_seen", 32'(gc_instruction != 8'h00), 32'd1);
  endtask

  task automatic vs_pulse();
    man_vs = 1'b1;
    tick(1);
    man_vs = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cif.cmd_valid = 1'b0;
    man_vs = 1'b0;
    man_busy = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // background clear engine and frame generator for the random phase
  initial forever begin
    @(negedge clk);
    if (auto_en && (gc_instruction == 8'h04 || gc_instruction == 8'h05)) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      eng_busy = 1'b1;
      repeat ($urandom_range(1, 8)) @(negedge clk);
      eng_busy = 1'b0;
    end
  end

  initial forever begin
    repeat ($urandom_range(2, 10)) @(negedge clk);
    gen_vs = ~gen_vs;
  end

  // observer: every new instruction issue becomes one transaction record
  logic [7:0]  prev_instr = 8'h00;
  logic [15:0] obs_q[$];
  initial forever begin
    @(negedge clk);
    if (auto_en && gc_instruction != 8'h00 && prev_instr == 8'h00)
      obs_q.push_back(gc_instruction >= 8'h04 ? {gc_instruction, 3'b000, gc_row}
                                              : {gc_instruction, gc_color});
    prev_instr = gc_instruction;
  end

  typedef struct {
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] e_instr;
    logic [7:0] e_color;
    logic [4:0] e_row;
    logic       e_err;
  } vec_t;

  vec_t vt[8];

  initial begin
    int bad;
    logic [15:0] exp_q[$];
    logic        exp_err;
    int          n_bad_op;
    int          n;

    vt[0] = '{8'h02, 8'h5A, 8'h02, 8'h5A, 5'd0,  1'b0};
    vt[1] = '{8'h03, 8'hA5, 8'h03, 8'hA5, 5'd0,  1'b0};
    vt[2] = '{8'h04, 8'hFF, 8'h04, 8'h00, 5'd0,  1'b0};
    vt[3] = '{8'h05, 8'h3F, 8'h05, 8'h00, 5'h1F, 1'b0};
    vt[4] = '{8'h05, 8'h0A, 8'h05, 8'h00, 5'h0A, 1'b0};
    vt[5] = '{8'h00, 8'h12, 8'h00, 8'h00, 5'd0,  1'b1};
    vt[6] = '{8'h06, 8'h33, 8'h00, 8'h00, 5'd0,  1'b1};
    vt[7] = '{8'hFF, 8'h04, 8'h00, 8'h00, 5'd0,  1'b1};

    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 8'h00;
    cif.cmd_arg   = 8'h00;
    #1;
    chk("rst_instr", 32'(gc_instruction), 32'h0);
    chk("rst_color", 32'(gc_color), 32'h0);
    chk("rst_row",   32'(gc_row), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_ready", 32'(cif.cmd_ready), 32'h1);
    tick(2);
    rst = 1'b0;
    tick(1);

    // single-command vectors
    for (int i = 0; i < 8; i++) begin
      do_reset();
      push(vt[i].op, vt[i].arg);
      tick(2);
      chk("vec_instr", 32'(gc_instruction), 32'(vt[i].e_instr));
      chk("vec_color", 32'(gc_color), 32'(vt[i].e_color));
      chk("vec_row",   32'(gc_row), 32'(vt[i].e_row));
      chk("vec_err",   32'(err), 32'(vt[i].e_err));
      if (vt[i].e_instr == 8'h02 || vt[i].e_instr == 8'h03) begin
        vs_pulse();
      end else if (vt[i].e_instr != 8'h00) begin
        tick(1);
        man_busy = 1'b1;
        tick(2);
        man_busy = 1'b0;
        tick(2);
      end
      chk("vec_idle", 32'(busy), 32'h0);
    end

    // colour command: latency, hold, release one cycle after the fall
    do_reset();
    push(OP_FONT, 8'hFF);
    tick(1);
    chk("lat_not_early", 32'(gc_instruction), 32'h0);
    tick(1);
    chk("font_instr", 32'(gc_instruction), 32'h02);
    chk("font_color", 32'(gc_color), 32'hFF);
    tick(3);
    man_vs = 1'b1;
    tick(1);
    chk("font_held", 32'(gc_instruction), 32'h02);
    man_vs = 1'b0;
    tick(1);
    chk("font_release", 32'(gc_instruction), 32'h0);
    chk("color_kept", 32'(gc_color), 32'hFF);
    chk("font_idle", 32'(busy), 32'h0);

    // a fall while the command is still being popped must not complete it
    man_vs = 1'b1;
    tick(1);
    push(OP_BG, 8'h3C);
    man_vs = 1'b0;
    tick(6);
    chk("early_fall_ignored", 32'(gc_instruction), 32'h03);
    vs_pulse();
    chk("bg_release", 32'(gc_instruction), 32'h0);

    // clear line with slow engine, next command held back
    do_reset();
    push(OP_CLR_LINE, 8'h05);
    push(OP_FONT, 8'h11);
    tick(1);
    chk("clr_pulse", 32'(gc_instruction), 32'h05);
    chk("clr_row", 32'(gc_row), 32'h05);
    tick(1);
    chk("pulse_one_cycle", 32'(gc_instruction), 32'h0);
    tick(1);
    man_busy = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (gc_instruction != 8'h00 || !busy) bad++;
    end
    chk("hold_during_clear", 32'(bad), 32'h0);
    man_busy = 1'b0;
    tick(2);
    chk("not_before_done", 32'(gc_instruction), 32'h0);
    tick(1);
    chk("next_after_clear", 32'(gc_instruction), 32'h02);
    chk("next_color", 32'(gc_color), 32'h11);
    chk("row_stable", 32'(gc_row), 32'h05);
    vs_pulse();

    // FIFO full with the FSM stalled in WAIT_VS
    do_reset();
    push(OP_FONT, 8'hA0);
    push(OP_BG,   8'hA1);
    push(OP_FONT, 8'hA2);
    push(OP_BG,   8'hA3);
    push(OP_FONT, 8'hA4);
    chk("full_ready_low", 32'(cif.cmd_ready), 32'h0);
    fork
      push(OP_BG, 8'hA5);
      begin
        tick(3);
        chk("still_full", 32'(cif.cmd_ready), 32'h0);
        vs_pulse();
      end
    join
    for (int k = 1; k <= 5; k++) begin
      wait_instr();
      chk("order_color", 32'(gc_color), 32'(8'hA0 + k));
      chk("order_instr", 32'(gc_instruction), (k % 2 == 1) ? 32'h03 : 32'h02);
      vs_pulse();
    end
    chk("full_drained", 32'(busy), 32'h0);

    // ack timeout abandons the clear and lets the queue move on
    do_reset();
    push(OP_CLR_SCR, 8'hFF);
    push(OP_BG, 8'h77);
    tick(1);
    chk("scr_pulse", 32'(gc_instruction), 32'h04);
    chk("scr_row", 32'(gc_row), 32'h0);
    tick(16);
    chk("err_not_early", 32'(err), 32'h0);
    tick(1);
    chk("timeout_err", 32'(err), 32'h1);
    chk("timeout_busy", 32'(busy), 32'h1);
    wait_instr();
    chk("after_to_instr", 32'(gc_instruction), 32'h03);
    chk("after_to_color", 32'(gc_color), 32'h77);
    vs_pulse();
`ifdef GC_SCHED_STATS_EN
    chk("to_drop_count", 32'(drop_count), 32'd1);
    chk("to_cmd_count", 32'(cmd_count), 32'd2);
`endif

    // illegal opcode is dropped
    do_reset();
    push(8'h07, 8'h12);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (gc_instruction != 8'h00) bad++;
    end
    chk("bad_op_quiet", 32'(bad), 32'h0);
    chk("bad_op_err", 32'(err), 32'h1);
    chk("bad_op_idle", 32'(busy), 32'h0);
`ifdef GC_SCHED_STATS_EN
    chk("bad_drop_count", 32'(drop_count), 32'd1);
    chk("bad_cmd_count", 32'(cmd_count), 32'd1);
`endif

    // reset while in CLR_DONE with commands queued
    do_reset();
    push(OP_CLR_LINE, 8'h09);
    push(OP_FONT, 8'h21);
    push(OP_BG, 8'h22);
    man_busy = 1'b1;
    tick(3);
    chk("pre_rst_row", 32'(gc_row), 32'h09);
    rst = 1'b1;
    #1;
    chk("mid_rst_instr", 32'(gc_instruction), 32'h0);
    chk("mid_rst_row", 32'(gc_row), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(cif.cmd_ready), 32'h1);
    chk("mid_rst_err", 32'(err), 32'h0);
    tick(1);
    rst = 1'b0;
    man_busy = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (gc_instruction != 8'h00 || busy) bad++;
    end
    chk("queue_discarded", 32'(bad), 32'h0);

    // randomized run against an in-order transaction model
    do_reset();
    obs_q.delete();
    exp_err  = 1'b0;
    n_bad_op = 0;
    auto_en  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [7:0] op, arg;
      r   = $urandom_range(0, 9);
      arg = 8'($urandom);
      if (r < 3)      op = OP_FONT;
      else if (r < 5) op = OP_BG;
      else if (r < 7) op = OP_CLR_SCR;
      else if (r < 9) op = OP_CLR_LINE;
      else            op = 8'(8'h06 + $urandom_range(0, 200));
      if (op == OP_FONT || op == OP_BG)  exp_q.push_back({op, arg});
      else if (op == OP_CLR_SCR)         exp_q.push_back({op, 8'h00});
      else if (op == OP_CLR_LINE)        exp_q.push_back({op, 3'b000, arg[4:0]});
      else begin
        exp_err = 1'b1;
        n_bad_op++;
      end
      tick($urandom_range(0, 3));
      push(op, arg);
    end
    n = 0;
    while (busy && n < 5000) begin
      tick(1);
      n++;
    end
    chk("rand_drain", 32'(busy), 32'h0);
    auto_en = 1'b0;
    chk("rand_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk("rand_order", 32'(obs_q[i]), 32'(exp_q[i]));
    chk("rand_err", 32'(err), 32'(exp_err));
`ifdef GC_SCHED_STATS_EN
    chk("rand_cmd_count", 32'(cmd_count), 32'd40);
    chk("rand_drop_count", 32'(drop_count), 32'(n_bad_op));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
